// File: rtl/clock_distribution_seq.sv
// Staggered enable sequencer for the clock buffer array: one channel per slot on ramp-up,
// reverse order on ramp-down, plus a registered ATB monitor word.
module clock_distribution_seq #(
    parameter int unsigned N_THERM = 17,
    parameter int unsigned N_BIN   = 6,
    parameter int unsigned STAGGER = 4,
    parameter int unsigned MON_W   = 8
) (
    input  logic               clkin_i,
    input  logic               pdb_i,
    input  logic               en_req_i,
    input  logic [N_THERM-1:0] therm_mask_i,
    input  logic [N_BIN:0]     bin_mask_i,
    input  logic [1:0]         atb_ena_i,
    output logic [N_THERM-1:0] therm_en_o,
    output logic [N_BIN:0]     bin_en_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic [MON_W-1:0]   atb_mon_o
);

    localparam int unsigned NCh  = N_THERM + N_BIN + 1;
    localparam int unsigned PtrW = $clog2(NCh + 1);
    localparam int unsigned CntW = $clog2(STAGGER + 1);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(NCh - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(STAGGER - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StOff      = 2'd0,
        StRampUp   = 2'd1,
        StOn       = 2'd2,
        StRampDown = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NCh-1:0]    en_q, en_d;
    logic [NCh-1:0]    mask_q, mask_d;
    logic [MON_W-1:0]  atb_q, atb_d;

    logic              slot_done;

    assign slot_done = (cnt_q == CntLast);

    // Channel vector: thermometer slots first, then binary bits 0..N_BIN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        mask_d  = mask_q;

        unique case (state_q)
            StOff: begin
                if (en_req_i) begin
                    state_d = StRampUp;
                    mask_d  = {bin_mask_i, therm_mask_i};
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end

            StRampUp: begin
                if (!en_req_i) begin
                    // Abort: unwind from the last slot actually written.
                    cnt_d = '0;
                    if (ptr_q == '0) begin
                        state_d = StOff;
                    end else begin
                        state_d = StRampDown;
                        ptr_d   = ptr_q - PtrOne;
                    end
                end else if (slot_done) begin
                    en_d[ptr_q] = mask_q[ptr_q];
                    ptr_d       = ptr_q + PtrOne;
                    cnt_d       = '0;
                    if (ptr_q == PtrLast) begin
                        state_d = StOn;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StOn: begin
                if (!en_req_i) begin
                    state_d = StRampDown;
                    ptr_d   = PtrLast;
                    cnt_d   = '0;
                end
            end

            StRampDown: begin
                // A renewed request is ignored here; OFF picks it up once the ramp completes.
                if (slot_done) begin
                    en_d[ptr_q] = 1'b0;
                    cnt_d       = '0;
                    if (ptr_q == '0) begin
                        state_d = StOff;
                    end else begin
                        ptr_d = ptr_q - PtrOne;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            default: state_d = StOff;
        endcase
    end

    always_comb begin
        atb_d = '0;
        unique case (atb_ena_i)
            2'b00: atb_d = '0;
            2'b01: atb_d = MON_W'($countones(en_q[N_THERM-1:0]));
            2'b10: atb_d = MON_W'($countones(en_q[NCh-1:N_THERM]));
            2'b11: atb_d = MON_W'({ptr_q, state_q});
            default: atb_d = '0;
        endcase
    end

    always_ff @(posedge clkin_i or negedge pdb_i) begin
        if (!pdb_i) begin
            state_q <= StOff;
            ptr_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            mask_q  <= '0;
            atb_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            atb_q   <= atb_d;
        end
    end

    assign therm_en_o = en_q[N_THERM-1:0];
    assign bin_en_o   = en_q[NCh-1:N_THERM];
    assign ready_o    = (state_q == StOn);
    assign busy_o     = (state_q == StRampUp) || (state_q == StRampDown);
    assign atb_mon_o  = atb_q;

endmodule

// File: tb/tb_clock_distribution_seq.sv
// Directed bench for clock_distribution_seq: expectations are queued with the edge they are due
// on and checked by a per-edge monitor; asynchronous reset effects are checked directly.
module tb_clock_distribution_seq;

    localparam int SelTherm = 0;
    localparam int SelBin   = 1;
    localparam int SelRb    = 2;  // {ready, busy}
    localparam int SelAtb   = 3;

    logic        clk;
    logic        pdb;
    logic        en_req;
    logic [16:0] therm_mask;
    logic [6:0]  bin_mask;
    logic [1:0]  atb_ena;
    logic [16:0] therm_en;
    logic [6:0]  bin_en;
    logic        ready;
    logic        busy;
    logic [7:0]  atb_mon;

    typedef struct {
        int unsigned due;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int unsigned e0;
    int unsigned e1;

    clock_distribution_seq #(
        .N_THERM(17),
        .N_BIN  (6),
        .STAGGER(4),
        .MON_W  (8)
    ) dut (
        .clkin_i     (clk),
        .pdb_i       (pdb),
        .en_req_i    (en_req),
        .therm_mask_i(therm_mask),
        .bin_mask_i  (bin_mask),
        .atb_ena_i   (atb_ena),
        .therm_en_o  (therm_en),
        .bin_en_o    (bin_en),
        .ready_o     (ready),
        .busy_o      (busy),
        .atb_mon_o   (atb_mon)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SelTherm: return 32'(therm_en);
            SelBin:   return 32'(bin_en);
            SelRb:    return 32'({ready, busy});
            default:  return 32'(atb_mon);
        endcase
    endfunction

    task automatic push(input int unsigned due, input int sel, input logic [31:0] val,
                        input string tag);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Pop and compare every expectation due on this edge, 1 ns after it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick_to(input int unsigned target);
        while (cyc < target) tick(1);
    endtask

    initial begin
        pdb        = 1'b1;
        en_req     = 1'b0;
        therm_mask = '1;
        bin_mask   = '1;
        atb_ena    = 2'b11;
        #1 pdb = 1'b0;
        #2;
        check("rst_therm", 32'(therm_en), 32'h0);
        check("rst_bin", 32'(bin_en), 32'h0);
        check("rst_ready_busy", 32'({ready, busy}), 32'h0);
        check("rst_atb", 32'(atb_mon), 32'h0);
        tick(2);
        pdb = 1'b1;
        tick(2);
        push(cyc + 1, SelAtb, 32'h0, "off_atb_state");
        tick(1);

        // Full ramp-up, all channels permitted
        atb_ena = 2'b00;
        en_req  = 1'b1;
        e0      = cyc + 1;
        push(e0 + 1, SelRb, 32'h1, "up_busy");
        push(e0 + 3, SelTherm, 32'h0, "up_slot0_early");
        push(e0 + 4, SelTherm, 32'h1, "up_slot0");
        push(e0 + 95, SelBin, 32'h3F, "up_bin6_early");
        push(e0 + 95, SelRb, 32'h1, "up_not_ready");
        push(e0 + 96, SelBin, 32'h7F, "up_bin6");
        push(e0 + 96, SelRb, 32'h2, "up_ready");
        push(e0 + 96, SelTherm, 32'h1FFFF, "up_therm_all");
        tick_to(e0 + 97);
        atb_ena = 2'b01;
        push(cyc + 1, SelAtb, 32'd17, "on_atb_therm");
        tick(1);
        atb_ena = 2'b10;
        push(cyc + 1, SelAtb, 32'd7, "on_atb_bin");
        tick(1);
        atb_ena = 2'b11;
        push(cyc + 1, SelAtb, 32'd98, "on_atb_state");
        tick(1);

        // Ramp-down from ON
        en_req = 1'b0;
        e1     = cyc + 1;
        push(e1, SelRb, 32'h1, "dn_ready_drop");
        push(e1 + 1, SelAtb, 32'd95, "dn_atb_state");
        push(e1 + 3, SelBin, 32'h7F, "dn_bin6_early");
        push(e1 + 4, SelBin, 32'h3F, "dn_bin6_off");
        push(e1 + 95, SelTherm, 32'h1, "dn_slot0_early");
        push(e1 + 96, SelTherm, 32'h0, "dn_slot0_off");
        push(e1 + 96, SelRb, 32'h0, "dn_off");
        push(e1 + 97, SelAtb, 32'h0, "dn_atb_off");
        tick_to(e1 + 98);

        // Masked ramp: timing unchanged, masked slots stay low
        therm_mask = 17'h0AAAA;
        bin_mask   = 7'h7F;
        en_req     = 1'b1;
        e0         = cyc + 1;
        push(e0 + 4, SelTherm, 32'h0, "mask_slot0");
        push(e0 + 8, SelTherm, 32'h2, "mask_slot1");
        push(e0 + 95, SelRb, 32'h1, "mask_not_ready");
        push(e0 + 96, SelRb, 32'h2, "mask_ready");
        push(e0 + 96, SelTherm, 32'h0AAAA, "mask_therm");
        push(e0 + 96, SelBin, 32'h7F, "mask_bin");
        tick_to(e0 + 96);
        therm_mask = '0;
        bin_mask   = '0;
        atb_ena    = 2'b01;
        push(cyc + 1, SelAtb, 32'd8, "mask_atb_therm");
        tick(1);
        atb_ena = 2'b10;
        push(cyc + 1, SelAtb, 32'd7, "mask_atb_bin");
        push(cyc + 2, SelTherm, 32'h0AAAA, "mask_on_hold");
        tick(2);
        en_req = 1'b0;
        e1     = cyc + 1;
        push(e1 + 96, SelTherm, 32'h0, "mask_dn_therm");
        push(e1 + 96, SelBin, 32'h0, "mask_dn_bin");
        push(e1 + 96, SelRb, 32'h0, "mask_dn_off");
        tick_to(e1 + 97);
        therm_mask = '1;
        bin_mask   = '1;

        // Abort after two slots
        atb_ena = 2'b11;
        en_req  = 1'b1;
        e0      = cyc + 1;
        push(e0 + 8, SelTherm, 32'h3, "ab_two_slots");
        push(e0 + 11, SelRb, 32'h1, "ab_busy");
        push(e0 + 12, SelAtb, 32'd7, "ab_atb_ptr");
        push(e0 + 14, SelTherm, 32'h3, "ab_slot1_early");
        push(e0 + 15, SelTherm, 32'h1, "ab_slot1_off");
        push(e0 + 18, SelTherm, 32'h1, "ab_slot0_early");
        push(e0 + 19, SelTherm, 32'h0, "ab_slot0_off");
        push(e0 + 19, SelRb, 32'h0, "ab_off");
        push(e0 + 20, SelAtb, 32'h0, "ab_atb_off");
        tick_to(e0 + 10);
        en_req = 1'b0;
        tick_to(e0 + 21);

        // Abort before any slot written goes straight to OFF
        en_req = 1'b1;
        e0     = cyc + 1;
        push(e0 + 1, SelRb, 32'h1, "ab0_busy");
        tick_to(e0 + 2);
        en_req = 1'b0;
        push(e0 + 3, SelRb, 32'h0, "ab0_off");
        push(e0 + 3, SelTherm, 32'h0, "ab0_therm");
        push(e0 + 4, SelAtb, 32'h0, "ab0_atb");
        tick_to(e0 + 5);

        // Re-request during ramp-down
        en_req = 1'b1;
        e0     = cyc + 1;
        push(e0 + 96, SelRb, 32'h2, "rs_on");
        tick_to(e0 + 97);
        en_req = 1'b0;
        e1     = cyc + 1;
        tick_to(e1 + 40);
        en_req = 1'b1;
        push(e1 + 50, SelRb, 32'h1, "rs_still_down");
        push(e1 + 95, SelTherm, 32'h1, "rs_slot0_early");
        push(e1 + 96, SelTherm, 32'h0, "rs_all_off");
        push(e1 + 96, SelBin, 32'h0, "rs_bin_off");
        push(e1 + 96, SelRb, 32'h0, "rs_off_edge");
        push(e1 + 97, SelRb, 32'h1, "rs_restart");
        push(e1 + 100, SelTherm, 32'h0, "rs_slot0_pre");
        push(e1 + 101, SelTherm, 32'h1, "rs_slot0");
        tick_to(e1 + 102);
        en_req = 1'b0;
        push(cyc + 8, SelRb, 32'h0, "rs_abort_off");
        push(cyc + 8, SelTherm, 32'h0, "rs_abort_therm");
        tick(9);

        // Asynchronous power-down mid-ramp
        en_req = 1'b1;
        e0     = cyc + 1;
        push(e0 + 49, SelTherm, 32'hFFF, "pd_pre");
        tick_to(e0 + 50);
        #3 pdb = 1'b0;
        #1;
        check("pd_therm", 32'(therm_en), 32'h0);
        check("pd_bin", 32'(bin_en), 32'h0);
        check("pd_ready_busy", 32'({ready, busy}), 32'h0);
        check("pd_atb", 32'(atb_mon), 32'h0);
        tick(2);
        check("pd_hold_rb", 32'({ready, busy}), 32'h0);
        check("pd_hold_therm", 32'(therm_en), 32'h0);
        pdb = 1'b1;
        e0  = cyc + 1;
        push(e0 + 1, SelRb, 32'h1, "pd_re_busy");
        push(e0 + 3, SelTherm, 32'h0, "pd_slot0_early");
        push(e0 + 4, SelTherm, 32'h1, "pd_slot0");
        push(e0 + 95, SelRb, 32'h1, "pd_not_ready");
        push(e0 + 96, SelRb, 32'h2, "pd_ready");
        push(e0 + 96, SelTherm, 32'h1FFFF, "pd_therm_all");
        push(e0 + 96, SelBin, 32'h7F, "pd_bin_all");
        tick_to(e0 + 98);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
